// File: rtl/ir.sv
// Instruction register with one-cycle decode.
// An 8-bit instruction byte is captured on a load edge. It is decoded into an
// operation code, a zero-extended operand address and an illegal-encoding flag.
// All outputs come straight from registers, so no combinational path runs from
// the input to the outputs.
module ir (
   input  logic       clk,
   input  logic       rst,
   input  logic       ld,
   input  logic [7:0] in,
   output logic [7:0] op,
   output logic [7:0] ad,
   output logic       ill
);

   // Primary opcodes in in[7:5]. The codes 3'b101 and 3'b110 are reserved.
   localparam logic [2:0] cu_lda        = 3'b000;
   localparam logic [2:0] cu_sta        = 3'b001;
   localparam logic [2:0] cu_add        = 3'b010;
   localparam logic [2:0] cu_ban        = 3'b011;
   localparam logic [2:0] cu_jmp        = 3'b100;
   localparam logic [2:0] cu_long_begin = 3'b111;

   // Long sub-opcodes in in[4:0]. They are only meaningful under cu_long_begin.
   localparam logic [4:0] cu_cla  = 5'b00000;
   localparam logic [4:0] cu_com  = 5'b00001;
   localparam logic [4:0] cu_shr  = 5'b00010;
   localparam logic [4:0] cu_csl  = 5'b00011;
   localparam logic [4:0] cu_stop = 5'b00100;

   // Decoded operation codes presented on op.
   localparam logic [7:0] OP_NONE    = 8'h00;
   localparam logic [7:0] OP_LDA     = 8'h01;
   localparam logic [7:0] OP_STA     = 8'h02;
   localparam logic [7:0] OP_ADD     = 8'h03;
   localparam logic [7:0] OP_BAN     = 8'h04;
   localparam logic [7:0] OP_JMP     = 8'h05;
   localparam logic [7:0] OP_CLA     = 8'h10;
   localparam logic [7:0] OP_COM     = 8'h11;
   localparam logic [7:0] OP_SHR     = 8'h12;
   localparam logic [7:0] OP_CSL     = 8'h13;
   localparam logic [7:0] OP_STOP    = 8'h14;
   localparam logic [7:0] OP_ILLEGAL = 8'hFF;

   logic [2:0] primary;
   logic [4:0] field;
   logic       is_short;
   logic [7:0] op_next;
   logic [7:0] ad_next;
   logic       ill_next;
   logic [7:0] op_reg;
   logic [7:0] ad_reg;
   logic       ill_reg;

   assign primary = in[7:5];
   assign field   = in[4:0];

   // Decode the instruction byte into its operation code and legality flag.
   always_comb begin
      op_next  = OP_ILLEGAL;
      ill_next = 1'b1;
      is_short = 1'b0;
      case (primary)
         cu_lda: begin op_next = OP_LDA; ill_next = 1'b0; is_short = 1'b1; end
         cu_sta: begin op_next = OP_STA; ill_next = 1'b0; is_short = 1'b1; end
         cu_add: begin op_next = OP_ADD; ill_next = 1'b0; is_short = 1'b1; end
         cu_ban: begin op_next = OP_BAN; ill_next = 1'b0; is_short = 1'b1; end
         cu_jmp: begin op_next = OP_JMP; ill_next = 1'b0; is_short = 1'b1; end
         cu_long_begin: begin
            case (field)
               cu_cla:  begin op_next = OP_CLA;  ill_next = 1'b0; end
               cu_com:  begin op_next = OP_COM;  ill_next = 1'b0; end
               cu_shr:  begin op_next = OP_SHR;  ill_next = 1'b0; end
               cu_csl:  begin op_next = OP_CSL;  ill_next = 1'b0; end
               cu_stop: begin op_next = OP_STOP; ill_next = 1'b0; end
               default: begin op_next = OP_ILLEGAL; ill_next = 1'b1; end
            endcase
         end
         default: begin op_next = OP_ILLEGAL; ill_next = 1'b1; end
      endcase
   end

   // The operand address carries the field only for short instructions.
   // The upper bits are always zero.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi = gi + 1) begin : g_ad
         if (gi < 5) begin : g_low
            assign ad_next[gi] = is_short & field[gi];
         end else begin : g_high
            assign ad_next[gi] = 1'b0;
         end
      end
   endgenerate

   // Capture the decoded instruction on load. Reset wins over load.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_reg  <= OP_NONE;
         ad_reg  <= 8'h00;
         ill_reg <= 1'b0;
      end else if (ld) begin
         op_reg  <= op_next;
         ad_reg  <= ad_next;
         ill_reg <= ill_next;
      end
   end

   assign op  = op_reg;
   assign ad  = ad_reg;
   assign ill = ill_reg;

endmodule

// File: tb/tb_ir.sv
// Self-checking bench for the instruction register.
// A spec-level model predicts op/ad/ill. A compare process checks them on
// every falling edge, and directed loads carry hand-computed expectations.
module tb_ir;

   logic       clk;
   logic       rst;
   logic       ld;
   logic [7:0] in;
   logic [7:0] op;
   logic [7:0] ad;
   logic       ill;

   int checks   = 0;
   int failures = 0;

   ir dut (
      .clk(clk),
      .rst(rst),
      .ld (ld),
      .in (in),
      .op (op),
      .ad (ad),
      .ill(ill)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: map an instruction byte to {op, ad, ill} using the encoding tables.
   function automatic logic [16:0] model_decode(input logic [7:0] i);
      logic [7:0] short_tab [0:7];
      logic [7:0] long_tab  [0:31];
      logic [7:0] code;
      logic [7:0] addr;
      short_tab = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hFF, 8'hFF, 8'h00};
      for (int k = 0; k < 32; k++) long_tab[k] = 8'hFF;
      long_tab[0] = 8'h10;
      long_tab[1] = 8'h11;
      long_tab[2] = 8'h12;
      long_tab[3] = 8'h13;
      long_tab[4] = 8'h14;
      if (i[7:5] == 3'b111) code = long_tab[i[4:0]];
      else                  code = short_tab[i[7:5]];
      addr = (i[7:5] <= 3'd4) ? {3'b000, i[4:0]} : 8'h00;
      return {code, addr, code == 8'hFF};
   endfunction

   logic [7:0] exp_op;
   logic [7:0] exp_ad;
   logic       exp_ill;
   logic       model_valid = 1'b0;

   // Model state: reset clears it, load captures the decoded byte, otherwise it holds.
   always @(posedge clk) begin
      if (rst) begin
         exp_op      <= 8'h00;
         exp_ad      <= 8'h00;
         exp_ill     <= 1'b0;
         model_valid <= 1'b1;
      end else if (ld) begin
         {exp_op, exp_ad, exp_ill} <= model_decode(in);
      end
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, req, $time);
      end
   endtask

   // Compare the DUT against the model on every falling edge once reset has been seen.
   always @(negedge clk) begin
      if (model_valid) begin
         check("model_op", op, exp_op);
         check("model_ad", ad, exp_ad);
         check("model_ill", {7'b0, ill}, {7'b0, exp_ill});
      end
   end

   // Apply one clock edge with the given inputs, then check literal expectations.
   task automatic step(input string name, input logic r, input logic l, input logic [7:0] v,
                       input logic [7:0] e_op, input logic [7:0] e_ad, input logic e_ill);
      rst = r;
      ld  = l;
      in  = v;
      @(posedge clk);
      #1;
      check({name, "_op"}, op, e_op);
      check({name, "_ad"}, ad, e_ad);
      check({name, "_ill"}, {7'b0, ill}, {7'b0, e_ill});
      $display("step %-10s rst=%0b ld=%0b in=%02h -> op=%02h ad=%02h ill=%0b",
               name, r, l, v, op, ad, ill);
   endtask

   logic [16:0] pin;

   initial begin
      rst = 1'b1;
      ld  = 1'b0;
      in  = 8'h00;
      #1;

      // Pin the model itself against hand-computed decodes.
      pin = model_decode(8'h48);  check("pin_add", pin[16:9], 8'h03); check("pin_add_ad", pin[8:1], 8'h08);
      pin = model_decode(8'hE4);  check("pin_stop", pin[16:9], 8'h14);
      pin = model_decode(8'hC1);  check("pin_rsv", pin[16:9], 8'hFF); check("pin_rsv_ill", {7'b0, pin[0]}, 8'h01);

      // Reset for two cycles, then idle.
      step("rst0", 1, 0, 8'h00, 8'h00, 8'h00, 0);
      step("rst1", 1, 0, 8'h00, 8'h00, 8'h00, 0);
      step("idle0", 0, 0, 8'h21, 8'h00, 8'h00, 0);
      step("idle1", 0, 0, 8'hE3, 8'h00, 8'h00, 0);

      // Back-to-back short instructions.
      step("lda", 0, 1, 8'h01, 8'h01, 8'h01, 0);
      step("add", 0, 1, 8'h41, 8'h03, 8'h01, 0);
      step("sta", 0, 1, 8'h21, 8'h02, 8'h01, 0);
      step("ban", 0, 1, 8'h61, 8'h04, 8'h01, 0);
      step("jmp", 0, 1, 8'h88, 8'h05, 8'h08, 0);

      // Back-to-back long instructions.
      step("csl", 0, 1, 8'hE3, 8'h13, 8'h00, 0);
      step("shr", 0, 1, 8'hE2, 8'h12, 8'h00, 0);
      step("com", 0, 1, 8'hE1, 8'h11, 8'h00, 0);
      step("cla", 0, 1, 8'hE0, 8'h10, 8'h00, 0);
      step("stop", 0, 1, 8'hE4, 8'h14, 8'h00, 0);

      // Reserved primary opcode, then reserved sub-opcode.
      step("rsv_a3", 0, 1, 8'hA3, 8'hFF, 8'h00, 1);
      step("rsv_ff", 0, 1, 8'hFF, 8'hFF, 8'h00, 1);
      step("rsv_c5", 0, 1, 8'hC5, 8'hFF, 8'h00, 1);

      // Hold behaviour while the input toggles.
      step("jmp1f", 0, 1, 8'h9F, 8'h05, 8'h1F, 0);
      step("hold0", 0, 0, 8'h00, 8'h05, 8'h1F, 0);
      step("hold1", 0, 0, 8'hFF, 8'h05, 8'h1F, 0);
      step("hold2", 0, 0, 8'h41, 8'h05, 8'h1F, 0);

      // Reset takes priority over a simultaneous load.
      step("rst_ld", 1, 1, 8'h42, 8'h00, 8'h00, 0);
      step("post0", 0, 0, 8'h42, 8'h00, 8'h00, 0);
      step("post_ld", 0, 1, 8'h42, 8'h03, 8'h02, 0);

      // Reset in the middle of a hold after an illegal load.
      step("ill2", 0, 1, 8'hBF, 8'hFF, 8'h00, 1);
      step("rst_mid", 1, 0, 8'h00, 8'h00, 8'h00, 0);

      ld = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ir.md
IR -- requirements
Module: ir

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 ld  input  1  load enable; when high, `in` is captured at the next rising clk.
REQ-004 in  input  8  instruction byte: in[7:5] = primary opcode, in[4:0] = address field or long sub-opcode.
REQ-005 op  output  8  registered decoded operation code (encoding per REQ-010).
REQ-006 ad  output  8  registered operand address, zero-extended {3'b000, addr[4:0]}.
REQ-007 ill  output  1  registered flag, high when the held instruction is not a legal encoding.

Function
REQ-008 The instruction encoding SHALL be shared through the control-unit header with these macros:
- Primary 3-bit opcodes: cu_lda=3'b000, cu_sta=3'b001, cu_add=3'b010, cu_ban=3'b011, cu_jmp=3'b100, cu_long_begin=3'b111.
- Reserved primary codes: 3'b101 and 3'b110.
REQ-009 Long 5-bit sub-opcodes, valid only when in[7:5]=cu_long_begin: cu_cla=5'b00000, cu_com=5'b00001, cu_shr=5'b00010, cu_csl=5'b00011, cu_stop=5'b00100; all other values are reserved.
REQ-010 op encoding SHALL be:
- NONE=8'h00
- LDA=8'h01, STA=8'h02, ADD=8'h03, BAN=8'h04, JMP=8'h05
- CLA=8'h10, COM=8'h11, SHR=8'h12, CSL=8'h13, STOP=8'h14
- ILLEGAL=8'hFF
REQ-011 Short instructions (lda/sta/add/ban/jmp) SHALL set op to the matching code and ad = {3'b000, in[4:0]}, ill=0.
REQ-012 Long instructions SHALL set op to the matching long code, ad = 8'h00, ill=0.
REQ-013 A reserved primary opcode or a reserved long sub-opcode SHALL set op = 8'hFF, ad = 8'h00, ill = 1.
REQ-014 Latency SHALL be exactly one clock: `in` sampled at edge N with ld=1 appears decoded on op/ad/ill immediately after edge N.
REQ-015 When ld=0 and rst=0, op/ad/ill SHALL hold their previous values indefinitely.
REQ-016 Outputs SHALL be driven only from registers; `in` SHALL have no combinational path to any output.
REQ-017 Back-to-back loads (ld held high) SHALL update the outputs every cycle with no bubble.

Reset
REQ-018 While rst=1 at a rising edge: op=8'h00, ad=8'h00, ill=0.
REQ-019 rst SHALL take priority over ld when both are high in the same cycle; the presented instruction is discarded.
REQ-020 After rst deasserts, outputs SHALL stay at reset values until the first edge with ld=1.
REQ-021 Asserting rst mid-sequence SHALL clear outputs at that edge; there is no other state to flush.

Verification
REQ-022 The bench SHALL cover these scenarios (each load is ld=1 for one edge):
- rst=1 for 2 cycles, then ld=0 -> op=00, ad=00, ill=0 throughout.
- Load {cu_lda,5'b00001}, {cu_add,5'b00001}, {cu_sta,5'b00001}, {cu_ban,5'b00001}, {cu_jmp,5'b01000} back-to-back -> op 01, 03, 02, 04, 05 with ad 01, 01, 01, 01, 08 on successive cycles.
- Load {cu_long_begin,cu_csl}, then shr, com, cla, stop -> op 13, 12, 11, 10, 14, with ad=00 and ill=0 each cycle.
- Load 8'hA3 (reserved primary), then 8'hFF (reserved sub-op) -> op=FF, ad=00, ill=1 both cycles.
- Load {cu_jmp,5'b11111}, then ld=0 for 3 cycles while `in` toggles -> op=05, ad=1F held.
- rst=1 and ld=1 with `in`={cu_add,5'b00010} in the same cycle -> op=00, ad=00, ill=0.
